sram_arbiter: RTL
=================

# sram_arbiter

Shares the single `sram_controller` instance between several read clients (video scan-out, maze renderer, game logic) and one buffered write client. It runs a free-running 4-cycle slot counter locked to the controller's internal frame. In each slot it presents one arbitrated read address and, when the write buffer is non-empty, one write. It sits between the client blocks and the controller's `rd_addr/rd_data/wr_en/wr_addr/wr_data` port.

## Interface
- `ADDR_W`, 20, SRAM word address width
- `DATA_W`, 32, SRAM data width
- `N_RD`, 3, number of read clients (≥2); client 0 is video
- `WF_DEPTH`, 4, write FIFO depth (power of two)

- `clk_100m`  in  1  system clock; the same clock drives `sram_controller`
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_req`  in  N_RD  per-client read request; level, held until granted
- `rd_addr_in`  in  N_RD*ADDR_W  client i address in bits [i*ADDR_W +: ADDR_W]
- `rd_gnt`  out  N_RD  one-hot, 1-cycle pulse: request accepted
- `rd_valid`  out  N_RD  one-hot, 1-cycle pulse: `rd_data_out` holds that client's word
- `rd_data_out`  out  DATA_W  shared read return data
- `wr_req`  in  1  write push request
- `wr_addr_in`  in  ADDR_W  write address
- `wr_data_in`  in  DATA_W  write data
- `wr_ready`  out  1  FIFO not full; push occurs when `wr_req && wr_ready`
- `wr_empty`  out  1  FIFO empty and no write in flight
- `sram_rd_addr`  out  ADDR_W  to controller `rd_addr`
- `sram_rd_data`  in  DATA_W  from controller `rd_data`
- `sram_wr_en`, `sram_wr_addr`, `sram_wr_data`  out  1/ADDR_W/DATA_W  to the controller's write port

## Operation
- `phase` is a 2-bit counter that increments 0→1→2→3→0 every cycle.
- The arbiter and the controller leave reset on the same edge, so `phase` equals the controller state.
- Read arbitration is evaluated combinationally during phase 3.
  - Client 0 has strict priority.
  - Otherwise, clients 1..N_RD-1 are served round-robin. The pointer moves to the client after the last one granted and changes only when one of those clients wins.
- At the edge ending phase 3, the winner's address is registered into `sram_rd_addr`, and the winner's index is registered into an in-flight tag.
  - `rd_gnt[winner]` is high throughout the following phase 0.
  - With no request, `sram_rd_addr` holds its value, no grant is issued, and the tag is marked invalid.
- The controller captures `rd_data` at the edge ending phase 2, so the word is visible during phase 3. At the edge ending phase 3 the arbiter registers `sram_rd_data` into `rd_data_out`. If the tag is valid, `rd_valid[tag]` is high for the next phase 0.
- Write path:
  - In phase 1, if the FIFO is non-empty, drive the head entry onto `sram_wr_addr`/`sram_wr_data` and set `sram_wr_en`, all registered.
  - `sram_wr_en` is high during phase 2 only.
  - The head entry is popped at the edge ending phase 2.
  - Result: at most one write per slot, executed in controller phase 3.
- No read/write coherence. A read of an address with a pending FIFO write returns the old data. Clients needing ordering wait for `wr_empty`.

## Timing
- Reset values:
  - `phase`=0, `rd_gnt`=0, `rd_valid`=0, `rd_data_out`=0
  - `sram_rd_addr`=0, `sram_wr_en`=0, `sram_wr_addr`=0, `sram_wr_data`=0
  - FIFO empty, so `wr_ready`=1 and `wr_empty`=1; RR pointer=1, tag invalid.
- Reset mid-slot aborts everything: the FIFO is flushed, in-flight reads produce no `rd_valid`, and `phase` restarts at 0.
- Read latency is fixed: `rd_valid` occurs exactly 4 cycles after `rd_gnt`. The client must hold `rd_addr_in` until it sees `rd_gnt`.
- Throughput is one read and one write per 4 cycles.
- The full flag is computed before the pop. A push in the same cycle as a pop while full is refused (`wr_ready`=0).
- A push into an empty FIFO during phase 1 is not written until the next slot, because `sram_wr_en` is decided at the edge ending phase 1 from the pre-push state.
- FIFO pointers are log2(WF_DEPTH)+1 bits, with wrap handled by the MSB compare.

## Structure
- Package `sram_arb_pkg` holds:
  - the phase constants `PH_ADDR`=0, `PH_WAIT`=1, `PH_CAP_WR`=2, `PH_WE`=3
  - `ADDR_W`/`DATA_W` defaults
- One sub-module, `sram_wr_fifo`: synchronous FIFO, parameterised depth, async active-low reset, push/pop/full/empty.

## Test plan
- Client 1 requests address 0x00010 with SRAM model word 0xDEADBEEF → `rd_gnt[1]` in phase 0 of slot k; `rd_valid[1]` with `rd_data_out`=0xDEADBEEF 4 cycles later.
- Clients 0, 1 and 2 all request continuously → grant order 0,0,0…; clients 1 and 2 are never granted. Then drop client 0 → grants alternate 1,2,1,2.
- Push 4 writes (0x100..0x103, data 0xA0..0xA3) in consecutive cycles:
  - `wr_ready` falls after the 4th push.
  - One `sram_wr_en` pulse per slot, in phase 2, in order.
  - `wr_empty` is high after the 4th write's phase 3.
- Full FIFO with a push in the phase-2 pop cycle → the push is refused, and exactly 4 writes reach the SRAM.
- Assert `rst_n` low in phase 2 with a read in flight and 2 queued writes → no `rd_valid`, no further `sram_wr_en`, all outputs at their reset values, and `phase`=0 after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: slot phases shared with sram_controller and default SRAM port widths
package sram_arb_pkg;
    typedef enum logic [1:0] {
        PH_ADDR   = 2'd0,
        PH_WAIT   = 2'd1,
        PH_CAP_WR = 2'd2,
        PH_WE     = 2'd3
    } phase_t;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 32;
endpackage

// File: rtl/sram_wr_fifo.sv
// sram_wr_fifo: synchronous write-request FIFO; full is taken before any same-cycle pop
module sram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 52
) (
    input  logic         clk_100m,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk_100m or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    always_ff @(posedge clk_100m)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: slot-locked read arbitration and buffered writes onto the single sram_controller
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int N_RD = 3,
    parameter int WF_DEPTH = 4
) (
    input  logic                     clk_100m,
    input  logic                     rst_n,
    input  logic [N_RD-1:0]          rd_req,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr_in,
    output logic [N_RD-1:0]          rd_gnt,
    output logic [N_RD-1:0]          rd_valid,
    output logic [DATA_W-1:0]        rd_data_out,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr_in,
    input  logic [DATA_W-1:0]        wr_data_in,
    output logic                     wr_ready,
    output logic                     wr_empty,
    output logic [ADDR_W-1:0]        sram_rd_addr,
    input  logic [DATA_W-1:0]        sram_rd_data,
    output logic                     sram_wr_en,
    output logic [ADDR_W-1:0]        sram_wr_addr,
    output logic [DATA_W-1:0]        sram_wr_data
);
    localparam int IW = $clog2(N_RD);
    phase_t phase;
    logic [IW-1:0] rr, win, tag;
    logic win_vld, tag_vld, slot_end, issue, wr_pend, f_full, f_empty;
    logic [ADDR_W+DATA_W-1:0] f_head;
    function automatic int rr_cand(input int p, input int j);
        return 1 + (p - 1 + j) % (N_RD - 1);
    endfunction
    assign slot_end = phase == PH_WE;
    assign issue = (phase == PH_WAIT) && !f_empty;
    assign wr_ready = !f_full;
    assign wr_empty = f_empty && !wr_pend;
    // video wins outright; the rest are scanned from rr, lowest offset last so it wins
    always_comb begin
        win_vld = rd_req[0];
        win = '0;
        if (!rd_req[0])
            for (int j = N_RD - 2; j >= 0; j--)
                if (rd_req[rr_cand(int'(rr), j)]) begin
                    win_vld = 1'b1;
                    win = IW'(rr_cand(int'(rr), j));
                end
    end
    always_ff @(posedge clk_100m or negedge rst_n)
        if (!rst_n) phase <= PH_ADDR;
        else phase <= phase_t'(phase + 2'd1);
    always_ff @(posedge clk_100m or negedge rst_n)
        if (!rst_n) begin
            rd_gnt <= '0;
            rd_valid <= '0;
            rd_data_out <= '0;
            sram_rd_addr <= '0;
            rr <= IW'(1);
            tag <= '0;
            tag_vld <= 1'b0;
        end else begin
            rd_gnt <= (slot_end && win_vld) ? N_RD'(1) << win : '0;
            rd_valid <= (slot_end && tag_vld) ? N_RD'(1) << tag : '0;
            if (slot_end) begin
                rd_data_out <= sram_rd_data;
                tag <= win;
                tag_vld <= win_vld;
                if (win_vld) sram_rd_addr <= rd_addr_in[int'(win)*ADDR_W +: ADDR_W];
                if (win_vld && win != '0) rr <= (win == IW'(N_RD - 1)) ? IW'(1) : win + IW'(1);
            end
        end
    always_ff @(posedge clk_100m or negedge rst_n)
        if (!rst_n) begin
            sram_wr_en <= 1'b0;
            sram_wr_addr <= '0;
            sram_wr_data <= '0;
            wr_pend <= 1'b0;
        end else begin
            sram_wr_en <= issue;
            wr_pend <= issue || (wr_pend && !slot_end);
            if (issue) {sram_wr_addr, sram_wr_data} <= f_head;
        end
    sram_wr_fifo #(.DEPTH(WF_DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
        .clk_100m(clk_100m),
        .rst_n(rst_n),
        .push(wr_req && !f_full),
        .din({wr_addr_in, wr_data_in}),
        .pop(sram_wr_en),
        .dout(f_head),
        .full(f_full),
        .empty(f_empty)
    );
endmodule
